// File: rtl/stage_mem1.sv
// Memory stage: registers execute results, runs the data-cache handshake, aligns loads, flags misalignment.
// One-cycle register latency; a memory op stalls upstream until the cache completes, and outputs hold while wb_stall.
module stage_mem1 #(
  parameter int XLEN = 32
) (
  input  logic            clk_core,
  input  logic            reset_n,
  input  logic            ex_valid,
  input  logic            ex_exc,
  input  logic [3:0]      ex_exc_cause,
  input  logic            ex_flush,
  input  logic [29:0]     ex_pc,
  input  logic [4:0]      ex_wb_reg,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [1:0]      ex_mem_size,
  input  logic            ex_mem_unsigned,
  input  logic [XLEN-1:0] ex_wdata,
  output logic            mem1_stall,
  input  logic            wb_stall,
  input  logic            csr_kill,
  output logic            dc_req,
  output logic            dc_we,
  output logic [XLEN-3:0] dc_addr,
  output logic [3:0]      dc_be,
  output logic [XLEN-1:0] dc_wdata,
  input  logic            dc_ready,
  input  logic            dc_rvalid,
  input  logic [XLEN-1:0] dc_rdata,
  output logic            mem1_valid_wb,
  output logic            mem1_exc,
  output logic [3:0]      mem1_exc_cause,
  output logic            mem1_flush,
  output logic [29:0]     mem1_pc,
  output logic            mem1_busy,
  output logic [4:0]      mem1_wb_reg,
  output logic [XLEN-1:0] mem1_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  logic            valid_q, valid_d;
  logic            exc_q, exc_d;
  logic [3:0]      cause_q, cause_d;
  logic            flush_q;
  logic [29:0]     pc_q;
  logic [4:0]      wb_reg_q;
  logic [XLEN-1:0] addr_q;
  logic            rd_q, wr_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            killed_q, killed_d;
  logic [1:0]      state_q, state_d;

  logic            advance;
  logic            access;
  logic            ex_misalign;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] load_data;

  assign access     = valid_q & (rd_q | wr_q) & ~exc_q & ~done_q;
  assign mem1_stall = access;
  assign advance    = ~mem1_stall & ~wb_stall;

  assign ex_misalign = ex_valid & ~ex_exc & (ex_mem_rd | ex_mem_wr) &
                       (((ex_mem_size == 2'd1) & ex_result[0]) |
                        ((ex_mem_size == 2'd2) & (ex_result[1:0] != 2'b00)));

  always_comb begin
    exc_d   = ex_exc | ex_misalign;
    cause_d = ex_exc_cause;
    if (ex_misalign) begin
      cause_d = ex_mem_rd ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (advance) begin
      valid_d = ex_valid;
    end
    if (csr_kill) begin
      valid_d = 1'b0;
    end
  end

  assign dc_addr = addr_q[XLEN-1:2];
  assign dc_we   = wr_q;

  always_comb begin
    case (size_q)
      2'd0: begin
        dc_be    = 4'b0001 << addr_q[1:0];
        dc_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        dc_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        dc_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        dc_be    = 4'b1111;
        dc_wdata = wdata_q;
      end
    endcase
  end

  assign rshift = dc_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    load_data = {{(XLEN-8){~uns_q & rshift[7]}}, rshift[7:0]};
      2'd1:    load_data = {{(XLEN-16){~uns_q & rshift[15]}}, rshift[15:0]};
      default: load_data = dc_rdata;
    endcase
  end

  // A killed load that was already accepted must still drain its response; killed_q marks that data as dead.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    killed_d = killed_q;
    dout_d   = dout_q;
    dc_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          dc_req = 1'b1;
          if (dc_ready) begin
            if (rd_q) begin
              state_d  = S_WAIT;
              killed_d = csr_kill;
            end else begin
              done_d = 1'b1;
            end
          end else if (!csr_kill) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        dc_req = 1'b1;
        if (dc_ready) begin
          if (rd_q) begin
            state_d  = S_WAIT;
            killed_d = csr_kill;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else if (csr_kill) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dc_rvalid) begin
          state_d  = S_IDLE;
          killed_d = 1'b0;
          if (!(killed_q | csr_kill)) begin
            done_d = 1'b1;
            dout_d = load_data;
          end
        end else if (csr_kill) begin
          killed_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      done_d = 1'b0;
      dout_d = ex_result;
    end
  end

  assign mem1_busy = (state_q == S_WAIT) | ((state_q == S_REQ) & dc_ready);

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      killed_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      killed_q <= killed_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      exc_q    <= 1'b0;
      cause_q  <= '0;
      flush_q  <= 1'b0;
      pc_q     <= '0;
      wb_reg_q <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
    end else if (advance) begin
      exc_q    <= exc_d;
      cause_q  <= cause_d;
      flush_q  <= ex_flush;
      pc_q     <= ex_pc;
      wb_reg_q <= ex_wb_reg;
      addr_q   <= ex_result;
      rd_q     <= ex_mem_rd;
      wr_q     <= ex_mem_wr;
      size_q   <= ex_mem_size;
      uns_q    <= ex_mem_unsigned;
      wdata_q  <= ex_wdata;
    end
  end

  assign mem1_valid_wb  = valid_q;
  assign mem1_exc       = exc_q;
  assign mem1_exc_cause = cause_q;
  assign mem1_flush     = flush_q;
  assign mem1_pc        = pc_q;
  assign mem1_wb_reg    = wb_reg_q;
  assign mem1_dout      = dout_q;

endmodule

// File: tb/tb_stage_mem1.sv
// Bench for stage_mem1: vector table with a retirement scoreboard, plus kill, writeback-hold and reset sequences.
module tb_stage_mem1;

  logic        clk_core, reset_n;
  logic        ex_valid, ex_exc, ex_flush, ex_mem_rd, ex_mem_wr, ex_mem_unsigned;
  logic [3:0]  ex_exc_cause;
  logic [29:0] ex_pc;
  logic [4:0]  ex_wb_reg;
  logic [31:0] ex_result, ex_wdata;
  logic [1:0]  ex_mem_size;
  logic        mem1_stall, wb_stall, csr_kill;
  logic        dc_req, dc_we, dc_ready, dc_rvalid;
  logic [29:0] dc_addr;
  logic [3:0]  dc_be;
  logic [31:0] dc_wdata, dc_rdata;
  logic        mem1_valid_wb, mem1_exc, mem1_flush, mem1_busy;
  logic [3:0]  mem1_exc_cause;
  logic [29:0] mem1_pc;
  logic [4:0]  mem1_wb_reg;
  logic [31:0] mem1_dout;

  stage_mem1 #(.XLEN(32)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_exc(ex_exc), .ex_exc_cause(ex_exc_cause), .ex_flush(ex_flush),
    .ex_pc(ex_pc), .ex_wb_reg(ex_wb_reg), .ex_result(ex_result),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_wdata(ex_wdata),
    .mem1_stall(mem1_stall), .wb_stall(wb_stall), .csr_kill(csr_kill),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_be(dc_be), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .mem1_valid_wb(mem1_valid_wb), .mem1_exc(mem1_exc), .mem1_exc_cause(mem1_exc_cause),
    .mem1_flush(mem1_flush), .mem1_pc(mem1_pc), .mem1_busy(mem1_busy),
    .mem1_wb_reg(mem1_wb_reg), .mem1_dout(mem1_dout)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns, exc;
    logic [3:0]  cause;
    logic [31:0] addr, wdata, rdata;
    int          rdy, rv;
    logic        x_exc;
    logic [3:0]  x_cause;
    logic        chk_dout;
    logic [31:0] x_dout;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        chk_dout;
    logic        exc;
    logic [3:0]  cause;
    logic [4:0]  wb;
    logic [29:0] pc;
    logic        flush;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wb,
                       input logic [29:0] pc);
    ex_valid = 1'b1; ex_exc = 1'b0; ex_exc_cause = 4'd0; ex_flush = 1'b0;
    ex_mem_rd = rd; ex_mem_wr = wr; ex_mem_size = sz; ex_mem_unsigned = uns;
    ex_result = addr; ex_wdata = wd; ex_wb_reg = wb; ex_pc = pc;
  endtask

  task automatic retire_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: retirement seen with no expected entry");
      return;
    end
    e = sb_q.pop_front();
    chk("exc", 32'(mem1_exc), 32'(e.exc));
    if (e.exc) chk("cause", 32'(mem1_exc_cause), 32'(e.cause));
    chk("wb_reg", 32'(mem1_wb_reg), 32'(e.wb));
    chk("pc", 32'(mem1_pc), 32'(e.pc));
    chk("flush", 32'(mem1_flush), 32'(e.flush));
    if (e.chk_dout) chk("dout", mem1_dout, e.dout);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    int          req_cnt, stall_cnt, wait_cnt, exp_req, exp_stall;
    bit          waiting, seen, fin, mem;
    logic [4:0]  wb;
    logic [29:0] pc;
    logic [31:0] idx_v;
    idx_v = 32'(idx);
    wb = 5'(idx + 5);
    pc = 30'h100 + 30'(idx);
    @(negedge clk_core);
    drive(v.rd, v.wr, v.size, v.uns, v.addr, v.wdata, wb, pc);
    ex_exc = v.exc; ex_exc_cause = v.cause; ex_flush = idx_v[0];
    e = '{v.x_dout, v.chk_dout, v.x_exc, v.x_cause, wb, pc, idx_v[0]};
    sb_q.push_back(e);
    req_cnt = 0; stall_cnt = 0; wait_cnt = 0; waiting = 0; seen = 0; fin = 0;
    for (int c = 0; c < 30 && !fin; c++) begin
      @(negedge clk_core);
      ex_valid = 1'b0;
      dc_ready = 1'b0;
      dc_rvalid = 1'b0;
      if (waiting) begin
        wait_cnt++;
        if (wait_cnt == 1) chk("busy_wait", 32'(mem1_busy), 32'd1);
        if (wait_cnt == v.rv) begin
          dc_rvalid = 1'b1;
          dc_rdata = v.rdata;
          waiting = 0;
        end
      end
      if (dc_req) begin
        req_cnt++;
        if (!seen) begin
          seen = 1;
          chk("dc_addr", 32'(dc_addr), {2'b00, v.addr[31:2]});
          chk("dc_be", 32'(dc_be), 32'(v.x_be));
          chk("dc_wdata", dc_wdata, v.x_wdata);
          chk("dc_we", 32'(dc_we), 32'(v.wr));
        end
        if (req_cnt > v.rdy) begin
          dc_ready = 1'b1;
          if (v.rd) begin
            waiting = 1;
            wait_cnt = 0;
          end
        end
      end
      if (mem1_stall) stall_cnt++;
      if (mem1_valid_wb && !mem1_stall) begin
        retire_check();
        fin = 1;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL retire_timeout: vector %0d never retired", idx);
    end
    mem = (v.rd | v.wr) & ~v.x_exc;
    exp_req   = mem ? v.rdy + 1 : 0;
    exp_stall = mem ? v.rdy + 1 + (v.rd ? v.rv : 0) : 0;
    chk("req_cycles", 32'(req_cnt), 32'(exp_req));
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
  endtask

  vec_t vecs[13];
  vec_t rst_vec;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; ex_valid = 1'b0; ex_exc = 1'b0; ex_exc_cause = 4'd0; ex_flush = 1'b0;
    ex_pc = '0; ex_wb_reg = '0; ex_result = '0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    ex_mem_size = 2'd0; ex_mem_unsigned = 1'b0; ex_wdata = '0;
    wb_stall = 1'b0; csr_kill = 1'b0; dc_ready = 1'b0; dc_rvalid = 1'b0; dc_rdata = '0;

    //         rd    wr    size  uns   exc   cause addr          wdata         rdata         rdy rv  x_exc x_cause chk   x_dout        x_be     x_wdata
    vecs[0]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,4'd0,32'h0000_1234,32'h0,        32'h0,        0, 1, 1'b0,4'd0,1'b1,32'h0000_1234,4'b0000,32'h0};
    vecs[1]  = '{1'b1,1'b0,2'd0,1'b0,1'b0,4'd0,32'h0000_0103,32'h0,        32'h80FF_FF00,0, 3, 1'b0,4'd0,1'b1,32'hFFFF_FF80,4'b1000,32'h0};
    vecs[2]  = '{1'b1,1'b0,2'd0,1'b1,1'b0,4'd0,32'h0000_0103,32'h0,        32'h80FF_FF00,0, 3, 1'b0,4'd0,1'b1,32'h0000_0080,4'b1000,32'h0};
    vecs[3]  = '{1'b0,1'b1,2'd1,1'b0,1'b0,4'd0,32'h0000_0202,32'h0000_BEEF,32'h0,        2, 1, 1'b0,4'd0,1'b0,32'h0,        4'b1100,32'hBEEF_BEEF};
    vecs[4]  = '{1'b1,1'b0,2'd2,1'b0,1'b0,4'd0,32'h0000_0101,32'h0,        32'h0,        0, 1, 1'b1,4'd4,1'b0,32'h0,        4'b0000,32'h0};
    vecs[5]  = '{1'b0,1'b1,2'd2,1'b0,1'b0,4'd0,32'h0000_0102,32'h1,        32'h0,        0, 1, 1'b1,4'd6,1'b0,32'h0,        4'b0000,32'h0};
    vecs[6]  = '{1'b1,1'b0,2'd1,1'b0,1'b0,4'd0,32'h0000_0102,32'h0,        32'h8001_7FFF,1, 1, 1'b0,4'd0,1'b1,32'hFFFF_8001,4'b1100,32'h0};
    vecs[7]  = '{1'b1,1'b0,2'd1,1'b1,1'b0,4'd0,32'h0000_0100,32'h0,        32'h1234_F00D,0, 2, 1'b0,4'd0,1'b1,32'h0000_F00D,4'b0011,32'h0};
    vecs[8]  = '{1'b1,1'b0,2'd2,1'b0,1'b0,4'd0,32'h0000_0104,32'h0,        32'hDEAD_BEEF,0, 1, 1'b0,4'd0,1'b1,32'hDEAD_BEEF,4'b1111,32'h0};
    vecs[9]  = '{1'b0,1'b1,2'd0,1'b0,1'b0,4'd0,32'h0000_0101,32'h0000_01A5,32'h0,        0, 1, 1'b0,4'd0,1'b0,32'h0,        4'b0010,32'hA5A5_A5A5};
    vecs[10] = '{1'b1,1'b0,2'd1,1'b0,1'b1,4'd5,32'h0000_0101,32'h0,        32'h0,        0, 1, 1'b1,4'd5,1'b0,32'h0,        4'b0000,32'h0};
    vecs[11] = '{1'b0,1'b1,2'd2,1'b0,1'b0,4'd0,32'h0000_0208,32'h1122_3344,32'h0,        1, 1, 1'b0,4'd0,1'b0,32'h0,        4'b1111,32'h1122_3344};
    vecs[12] = '{1'b1,1'b0,2'd0,1'b0,1'b0,4'd0,32'h0000_0100,32'h0,        32'h0000_007F,0, 1, 1'b0,4'd0,1'b1,32'h0000_007F,4'b0001,32'h0};
    rst_vec  = '{1'b1,1'b0,2'd2,1'b0,1'b0,4'd0,32'h0000_0504,32'h0,        32'hCAFE_F00D,1, 2, 1'b0,4'd0,1'b1,32'hCAFE_F00D,4'b1111,32'h0};

    #3;
    chk("rst_valid", 32'(mem1_valid_wb), 32'd0);
    chk("rst_exc", 32'(mem1_exc), 32'd0);
    chk("rst_flush", 32'(mem1_flush), 32'd0);
    chk("rst_busy", 32'(mem1_busy), 32'd0);
    chk("rst_dc_req", 32'(dc_req), 32'd0);
    chk("rst_stall", 32'(mem1_stall), 32'd0);
    @(negedge clk_core);
    @(negedge clk_core);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Kill an accepted load in WAIT; the next load must not issue until the dead response drains.
    @(negedge clk_core);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 5'd8, 30'h2);
    @(negedge clk_core);
    ex_valid = 1'b0;
    chk("kill_req", 32'(dc_req), 32'd1);
    dc_ready = 1'b1;
    @(negedge clk_core);
    dc_ready = 1'b0;
    chk("kill_busy_pre", 32'(mem1_busy), 32'd1);
    csr_kill = 1'b1;
    @(negedge clk_core);
    csr_kill = 1'b0;
    chk("kill_valid_drop", 32'(mem1_valid_wb), 32'd0);
    chk("kill_busy_held", 32'(mem1_busy), 32'd1);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 5'd9, 30'h3);
    sb_q.push_back('{32'h5555_5555, 1'b1, 1'b0, 4'd0, 5'd9, 30'h3, 1'b0});
    @(negedge clk_core);
    ex_valid = 1'b0;
    chk("kill_no_req", 32'(dc_req), 32'd0);
    chk("kill_next_stall", 32'(mem1_stall), 32'd1);
    chk("kill_busy_wait", 32'(mem1_busy), 32'd1);
    dc_rvalid = 1'b1;
    dc_rdata = 32'hAAAA_AAAA;
    @(negedge clk_core);
    dc_rvalid = 1'b0;
    chk("kill_next_req", 32'(dc_req), 32'd1);
    chk("kill_next_addr", 32'(dc_addr), 32'h0000_0100);
    chk("kill_busy_idle", 32'(mem1_busy), 32'd0);
    dc_ready = 1'b1;
    @(negedge clk_core);
    dc_ready = 1'b0;
    dc_rvalid = 1'b1;
    dc_rdata = 32'h5555_5555;
    @(negedge clk_core);
    dc_rvalid = 1'b0;
    chk("kill_next_valid", 32'(mem1_valid_wb), 32'd1);
    chk("kill_next_stall_done", 32'(mem1_stall), 32'd0);
    retire_check();

    // Completed store held by writeback: no re-issue, outputs stable.
    @(negedge clk_core);
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0600, 32'h1, 5'd0, 30'h4);
    @(negedge clk_core);
    ex_valid = 1'b0;
    chk("hold_req", 32'(dc_req), 32'd1);
    dc_ready = 1'b1;
    wb_stall = 1'b1;
    @(negedge clk_core);
    dc_ready = 1'b0;
    chk("hold_no_req", 32'(dc_req), 32'd0);
    chk("hold_stall", 32'(mem1_stall), 32'd0);
    chk("hold_valid", 32'(mem1_valid_wb), 32'd1);
    @(negedge clk_core);
    chk("hold_no_req2", 32'(dc_req), 32'd0);
    chk("hold_pc", 32'(mem1_pc), 32'h4);
    wb_stall = 1'b0;
    @(negedge clk_core);
    chk("hold_released", 32'(mem1_valid_wb), 32'd0);

    // Reset while a request sits in REQ.
    @(negedge clk_core);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 5'd7, 30'h5);
    @(negedge clk_core);
    ex_valid = 1'b0;
    chk("rstq_req", 32'(dc_req), 32'd1);
    @(negedge clk_core);
    chk("rstq_req_held", 32'(dc_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstq_dc_req", 32'(dc_req), 32'd0);
    chk("rstq_valid", 32'(mem1_valid_wb), 32'd0);
    chk("rstq_busy", 32'(mem1_busy), 32'd0);
    @(negedge clk_core);
    reset_n = 1'b1;
    run_vec(rst_vec, 13);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
